song_reader: RTL

SONG_READER -- requirements
Module: song_reader

---
 rtl/song_pkg.sv | 49 ++++
 rtl/song_reader_beat_countdown.sv | 36 +++
 rtl/song_reader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/song_pkg.sv
// Shared definitions for the song reader: ROM entry layout, entry type bit,
// FSM state encoding and field widths.
package song_pkg;

  localparam int ADDR_W = 6;
  localparam int WORD_W = 16;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;
  localparam int META_W = 3;
  localparam int CNT_W  = 6;

  // Entry layout: bit 15 selects NOTE (0) or ADVANCE (1).
  localparam int TYPE_BIT = 15;
  localparam int NOTE_MSB = 14;
  localparam int NOTE_LSB = 9;
  localparam int DUR_MSB  = 8;
  localparam int DUR_LSB  = 3;
  localparam int META_MSB = 2;
  localparam int META_LSB = 0;
  localparam int CNT_MSB  = 14;
  localparam int CNT_LSB  = 9;

  localparam logic TYPE_NOTE    = 1'b0;
  localparam logic TYPE_ADVANCE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EMIT   = 3'd3,
    ST_WAIT   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
    logic [META_W-1:0] meta;
  } note_t;

  function automatic note_t decode_note(input logic [WORD_W-1:0] w);
    note_t n;
    n.note     = w[NOTE_MSB:NOTE_LSB];
    n.duration = w[DUR_MSB:DUR_LSB];
    n.meta     = w[META_MSB:META_LSB];
    return n;
  endfunction

endpackage

// File: rtl/song_reader_beat_countdown.sv
// Beat countdown for ADVANCE entries: loadable 6-bit down counter that
// saturates at zero and flags when the next decrement finishes the wait.
module beat_countdown
  import song_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Independent of dec_i so the parent can combine it with the beat without a loop.
  assign last_o = (count_q <= CNT_W'(1));

endmodule

// File: rtl/song_reader.sv
// Song reader: walks a registered song ROM, offers NOTE entries downstream
// over a valid/ready handshake and times ADVANCE entries in beats.
//
// Handshake: note_valid stays high with note/duration/meta frozen until the
// cycle where note_valid && note_ready, which is the single transfer cycle.
module song_reader
  import song_pkg::*;
#(
  parameter int LAST_ADDR = 63,
  parameter int LOOP      = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              beat,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic              note_valid,
  input  logic              note_ready,
  output logic [NOTE_W-1:0] note,
  output logic [DUR_W-1:0]  duration,
  output logic [META_W-1:0] meta,
  output logic              song_done,
  output state_e            state_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  note_t             fields_q, fields_d;
  logic              done_q, done_d;

  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_last;
  logic             complete;
  logic [CNT_W-1:0] adv_cnt;

  assign adv_cnt = rom_data[CNT_MSB:CNT_LSB];

  beat_countdown u_countdown (
    .clk        (clk),
    .rst        (reset),
    .load_i     (cnt_load),
    .load_val_i (adv_cnt),
    .dec_i      (cnt_dec),
    .last_o     (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    fields_d = fields_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    complete = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (play) begin
          state_d = ST_FETCH;
          addr_d  = '0;
        end
      end
      ST_FETCH: begin
        if (play) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (play) begin
          if (rom_data[TYPE_BIT] == TYPE_NOTE) begin
            fields_d = decode_note(rom_data);
            state_d  = ST_EMIT;
          end else if (adv_cnt != '0) begin
            cnt_load = 1'b1;
            state_d  = ST_WAIT;
          end else begin
            complete = 1'b1;
          end
        end
      end
      // The handshake is honoured even while paused.
      ST_EMIT: begin
        if (note_ready) complete = 1'b1;
      end
      ST_WAIT: begin
        if (play && beat) begin
          cnt_dec = 1'b1;
          if (cnt_last) complete = 1'b1;
        end
      end
      ST_DONE: begin
        if (!play) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (complete) begin
      if (addr_q == LAST) begin
        done_d = 1'b1;
        if (LOOP != 0) begin
          addr_d  = '0;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DONE;
        end
      end else begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      fields_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      fields_q <= fields_d;
      done_q   <= done_d;
    end
  end

  assign rom_addr   = addr_q;
  assign note_valid = (state_q == ST_EMIT);
  assign note       = fields_q.note;
  assign duration   = fields_q.duration;
  assign meta       = fields_q.meta;
  assign song_done  = done_q;
  assign state_o    = state_q;

endmodule
